// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake,
// holds each instruction until retire, then advances the PC (sequential or taken beq).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch,
  input  logic             zero,
  input  logic [15:0]      imm,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               fetch_done;
  logic               retire;
  logic               taken;
  logic signed [31:0] imm_ext;
  logic signed [31:0] br_off;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;

  assign fetch_done = (state_q == REQ) && imem_ready;
  assign retire     = (state_q == HOLD) && instr_ready;

  // Branch target arithmetic wraps modulo 2^32 in both directions.
  assign imm_ext  = 32'(signed'(imm));
  assign br_off   = imm_ext <<< 2;
  assign pc_plus4 = pc_q + 32'd4;
  assign taken    = branch & zero;
  assign next_pc  = taken ? (pc_plus4 + $unsigned(br_off)) : pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run)         state_d = REQ;
      REQ:     if (imem_ready)  state_d = HOLD;
      HOLD:    if (instr_ready) state_d = run ? REQ : IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      REQ:     imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // rdata is captured only on the REQ/ready handshake; PC and count move only on retire.
  always_comb begin
    instr_d   = fetch_done ? imem_rdata : instr_q;
    pc_d      = retire ? next_pc : pc_q;
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one default instance plus a wrap instance
// (RESET_PC near the top of the address space, 2-bit retire counter).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n, rst_n_w;
  logic        run, run_w;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_ready, branch, zero;
  logic [15:0] imm;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, retired;
  logic [5:0]  opcode, funct;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [5:0]  w_opcode, w_funct;
  logic [1:0]  w_retired;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .zero(zero), .imm(imm),
    .pc(pc), .retired(retired)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .run(run_w),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(w_instr), .opcode(w_opcode), .funct(w_funct),
    .instr_valid(w_valid), .instr_ready(instr_ready),
    .branch(branch), .zero(zero), .imm(imm),
    .pc(w_pc), .retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total_cnt);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; rst_n_w = 1'b0; run = 1'b0; run_w = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; imm = 16'd0;
    tick(); tick();
    total_cnt++; if (pc !== 32'd0) $display("FAIL rst_pc: got %h want %h", pc, 32'd0); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (retired !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired); else pass_cnt++;
    total_cnt++; if (instr !== 32'd0) $display("FAIL rst_instr: got %h want 0", instr); else pass_cnt++;
    total_cnt++; if (opcode !== 6'd0 || funct !== 6'd0) $display("FAIL rst_fields: got %b/%b want 0/0", opcode, funct); else pass_cnt++;
    rst_n = 1'b1; run = 1'b1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL release_req: got %b want 0", imem_req); else pass_cnt++;
    n = 0;
    while (imem_req !== 1'b1 && n < 2) begin
      tick();
      n++;
    end
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL start_req: got %b want 1 within 2 cycles", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'd0) $display("FAIL start_addr: got %h want %h", imem_addr, 32'd0); else pass_cnt++;
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005; instr_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rdata = 32'd0;
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL seq_valid: got %b want 1", instr_valid); else pass_cnt++;
    total_cnt++; if (instr !== 32'h2008_0005) $display("FAIL seq_instr0: got %h want %h", instr, 32'h2008_0005); else pass_cnt++;
    total_cnt++; if (opcode !== 6'b001000) $display("FAIL seq_opcode0: got %b want 001000", opcode); else pass_cnt++;
    total_cnt++; if (pc !== 32'd0) $display("FAIL seq_pc0: got %h want 0", pc); else pass_cnt++;
    tick();
    total_cnt++; if (pc !== 32'd4 || imem_addr !== 32'd4) $display("FAIL seq_pc4: got %h/%h want 4", pc, imem_addr); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) $display("FAIL seq_req1: got req=%b valid=%b want 1/0", imem_req, instr_valid); else pass_cnt++;
    total_cnt++; if (retired !== 32'd1) $display("FAIL seq_ret1: got %0d want 1", retired); else pass_cnt++;
    imem_ready = 1'b1; imem_rdata = 32'h0109_5020;
    tick();
    imem_ready = 1'b0; imem_rdata = 32'd0;
    total_cnt++; if (opcode !== 6'b000000 || funct !== 6'b100000) $display("FAIL seq_fields1: got %b/%b want 000000/100000", opcode, funct); else pass_cnt++;
    tick();
    total_cnt++; if (pc !== 32'd8 || imem_addr !== 32'd8) $display("FAIL seq_pc8: got %h/%h want 8", pc, imem_addr); else pass_cnt++;
    total_cnt++; if (retired !== 32'd2) $display("FAIL seq_ret2: got %0d want 2", retired); else pass_cnt++;
    instr_ready = 1'b0;
  endtask

  task automatic test_branch();
    imem_ready = 1'b1; imem_rdata = 32'h1000_FFFE;
    tick();
    imem_ready = 1'b0;
    total_cnt++; if (opcode !== 6'b000100) $display("FAIL br_opcode: got %b want 000100", opcode); else pass_cnt++;
    branch = 1'b1; zero = 1'b1; imm = 16'hFFFE; instr_ready = 1'b1;
    tick();
    total_cnt++; if (imem_addr !== 32'h0000_0004 || imem_req !== 1'b1) $display("FAIL br_taken_back: got %h req=%b want 00000004 req=1", imem_addr, imem_req); else pass_cnt++;
    instr_ready = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1000_0000;
    tick();
    imem_ready = 1'b0;
    branch = 1'b1; zero = 1'b1; imm = 16'h0000; instr_ready = 1'b1;
    tick();
    total_cnt++; if (imem_addr !== 32'h0000_0008) $display("FAIL br_taken_zero_off: got %h want 00000008", imem_addr); else pass_cnt++;
    instr_ready = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1000_FFFE;
    tick();
    imem_ready = 1'b0;
    branch = 1'b1; zero = 1'b0; imm = 16'hFFFE; instr_ready = 1'b1;
    tick();
    total_cnt++; if (imem_addr !== 32'h0000_000C) $display("FAIL br_not_taken: got %h want 0000000C", imem_addr); else pass_cnt++;
    total_cnt++; if (retired !== 32'd5) $display("FAIL br_retired: got %0d want 5", retired); else pass_cnt++;
    tick();
    total_cnt++; if (imem_req !== 1'b1 || pc !== 32'h0000_000C || retired !== 32'd5) $display("FAIL ready_in_req: got req=%b pc=%h ret=%0d want 1/0000000C/5", imem_req, pc, retired); else pass_cnt++;
    instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; imm = 16'd0;
  endtask

  task automatic test_wait_backpressure();
    imem_ready = 1'b0; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL wait_req%0d: got %b want 1", i, imem_req); else pass_cnt++;
      total_cnt++; if (imem_addr !== 32'h0000_000C) $display("FAIL wait_addr%0d: got %h want 0000000C", i, imem_addr); else pass_cnt++;
    end
    imem_ready = 1'b1; imem_rdata = 32'h8C09_0004;
    tick();
    total_cnt++; if (instr !== 32'h8C09_0004 || instr_valid !== 1'b1) $display("FAIL wait_latch: got %h valid=%b want 8C090004 valid=1", instr, instr_valid); else pass_cnt++;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (instr !== 32'h8C09_0004) $display("FAIL bp_instr%0d: got %h want 8C090004", i, instr); else pass_cnt++;
      total_cnt++; if (opcode !== 6'b100011 || funct !== 6'b000100) $display("FAIL bp_fields%0d: got %b/%b want 100011/000100", i, opcode, funct); else pass_cnt++;
      total_cnt++; if (retired !== 32'd5 || instr_valid !== 1'b1) $display("FAIL bp_hold%0d: got ret=%0d valid=%b want 5/1", i, retired, instr_valid); else pass_cnt++;
    end
    imem_ready = 1'b0; instr_ready = 1'b1;
    tick();
    total_cnt++; if (pc !== 32'h0000_0010 || retired !== 32'd6) $display("FAIL bp_retire: got pc=%h ret=%0d want 00000010/6", pc, retired); else pass_cnt++;
    instr_ready = 1'b0;
  endtask

  task automatic test_run_drop();
    run = 1'b0; imem_ready = 1'b0;
    tick();
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0010) $display("FAIL drop_req_held: got req=%b addr=%h want 1/00000010", imem_req, imem_addr); else pass_cnt++;
    imem_ready = 1'b1; imem_rdata = 32'h012A_4022;
    tick();
    imem_ready = 1'b0;
    total_cnt++; if (instr_valid !== 1'b1 || funct !== 6'b100010) $display("FAIL drop_hold: got valid=%b funct=%b want 1/100010", instr_valid, funct); else pass_cnt++;
    instr_ready = 1'b1;
    tick();
    total_cnt++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL drop_idle: got req=%b valid=%b want 0/0", imem_req, instr_valid); else pass_cnt++;
    total_cnt++; if (pc !== 32'h0000_0014 || retired !== 32'd7) $display("FAIL drop_pc: got pc=%h ret=%0d want 00000014/7", pc, retired); else pass_cnt++;
    instr_ready = 1'b0;
    tick();
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL drop_stay_idle: got %b want 0", imem_req); else pass_cnt++;
    run = 1'b1;
    tick();
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0014) $display("FAIL drop_resume: got req=%b addr=%h want 1/00000014", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (instr !== 32'd0 || pc !== 32'd0) $display("FAIL midrst_async: got instr=%h pc=%h want 0/0", instr, pc); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0 || retired !== 32'd0) $display("FAIL midrst_ctrl: got req=%b ret=%0d want 0/0", imem_req, retired); else pass_cnt++;
    tick();
    total_cnt++; if (instr !== 32'd0) $display("FAIL midrst_hold: got %h want 0", instr); else pass_cnt++;
    run = 1'b0; rst_n = 1'b1;
    tick();
    total_cnt++; if (imem_req !== 1'b0 || instr !== 32'd0 || instr_valid !== 1'b0) $display("FAIL midrst_ignore_ready: got req=%b instr=%h valid=%b want 0/0/0", imem_req, instr, instr_valid); else pass_cnt++;
    imem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    rst_n_w = 1'b1; run_w = 1'b1;
    tick();
    total_cnt++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_start: got req=%b addr=%h want 1/FFFFFFFC", w_req, w_addr); else pass_cnt++;
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ready = 1'b0; branch = 1'b0; zero = 1'b0; instr_ready = 1'b1;
    tick();
    total_cnt++; if (w_pc !== 32'h0000_0000 || w_retired !== 2'd1) $display("FAIL wrap_pc: got pc=%h ret=%0d want 00000000/1", w_pc, w_retired); else pass_cnt++;
    instr_ready = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; branch = 1'b1; zero = 1'b1; imm = 16'hFFFE; instr_ready = 1'b1;
    tick();
    total_cnt++; if (w_pc !== 32'hFFFF_FFFC || w_retired !== 2'd2) $display("FAIL wrap_neg_branch: got pc=%h ret=%0d want FFFFFFFC/2", w_pc, w_retired); else pass_cnt++;
    branch = 1'b0; zero = 1'b0; imm = 16'd0;
    for (int i = 0; i < 2; i++) begin
      instr_ready = 1'b0; imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0; instr_ready = 1'b1;
      tick();
    end
    instr_ready = 1'b0;
    total_cnt++; if (w_retired !== 2'd0 || w_pc !== 32'h0000_0004) $display("FAIL wrap_counter: got ret=%0d pc=%h want 0/00000004", w_retired, w_pc); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0 || pc !== 32'd0) $display("FAIL wrap_main_idle: got req=%b pc=%h want 0/0", imem_req, pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wait_backpressure();
    test_run_drop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
